// File: rtl/mcu_block_builder.sv
// Purpose : RGB pixels in MCU raster order -> YCbCr, level-shifted -> serial 8x8 blocks for the FDCT.
// Latency : 1-cycle conversion; first block sample valid 2 cycles after the last MCU pixel is accepted.
// Backpr. : pixel side stalls (o_pix_ready=0) for the whole drain; block side holds outputs while !i_blk_ready.
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_mode_420                   1 = 4:2:0 (16x16 MCU, 6 blocks), 0 = 4:4:4 (8x8 MCU, 3 blocks);
//                                sampled on the first pixel of each MCU
//   i_pix_r/g/b, i_pix_valid     unsigned 8-bit RGB pixel, accepted when valid && o_pix_ready
//   o_pix_ready                  high while filling the MCU buffer
//   o_blk_data                   signed sample -128..127, sign-extended to 16 bits
//   o_blk_valid, i_blk_ready     block-side handshake
//   o_blk_id                     0..3 = Y0..Y3, 4 = Cb, 5 = Cr
//   o_blk_first / o_blk_last     sample 0 of a block / sample 63 of the final Cr block
module mcu_block_builder #(
  parameter int FRAC = 10
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_mode_420,
  input  logic [7:0]  i_pix_r,
  input  logic [7:0]  i_pix_g,
  input  logic [7:0]  i_pix_b,
  input  logic        i_pix_valid,
  output logic        o_pix_ready,
  output logic [15:0] o_blk_data,
  output logic        o_blk_valid,
  input  logic        i_blk_ready,
  output logic [2:0]  o_blk_id,
  output logic        o_blk_first,
  output logic        o_blk_last
);

  typedef enum logic [1:0] {S_FILL, S_CONV, S_DRAIN} state_t;
  state_t r_state, w_state_nxt;

  logic [7:0] r_pix_cnt;
  logic       r_mode;
  logic [5:0] r_smp_cnt;
  logic [2:0] r_blk_cnt;

  // conversion pipeline register
  logic       r_p_vld, r_p_420;
  logic [7:0] r_p_r, r_p_g, r_p_b;
  logic [3:0] r_p_row, r_p_col;

  // sample storage; Y blocks packed as {blk[1:0], idx[5:0]}
  logic [7:0]        r_ybuf  [0:255];
  logic [7:0]        r_cbbuf [0:63];
  logic [7:0]        r_crbuf [0:63];
  logic signed [10:0] r_acc_cb [0:7];
  logic signed [10:0] r_acc_cr [0:7];

  logic       w_fill, w_drain, w_mode, w_pix_acc, w_pix_last;
  logic [3:0] w_row, w_col;
  logic [2:0] w_blk_id;
  logic       w_blk_end, w_mcu_end, w_blk_xfer;
  logic [7:0] w_rd;

  assign w_fill     = (r_state == S_FILL) && !i_rst;
  assign w_drain    = (r_state == S_DRAIN);
  // mode is taken live on the first pixel, then held for the rest of the MCU
  assign w_mode     = (r_pix_cnt == 8'd0) ? i_mode_420 : r_mode;
  assign w_pix_acc  = i_pix_valid && w_fill;
  assign w_row      = w_mode ? r_pix_cnt[7:4] : {1'b0, r_pix_cnt[5:3]};
  assign w_col      = w_mode ? r_pix_cnt[3:0] : {1'b0, r_pix_cnt[2:0]};
  assign w_pix_last = w_mode ? (r_pix_cnt == 8'd255) : (r_pix_cnt == 8'd63);

  // 4:4:4 emits block slots 0,1,2 as ids 0,4,5
  assign w_blk_id   = r_mode ? r_blk_cnt :
                      (r_blk_cnt == 3'd0) ? 3'd0 : (r_blk_cnt == 3'd1) ? 3'd4 : 3'd5;
  assign w_blk_end  = (r_smp_cnt == 6'd63);
  assign w_mcu_end  = w_blk_end && (w_blk_id == 3'd5);
  assign w_blk_xfer = w_drain && i_blk_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_FILL;
      r_pix_cnt <= 8'd0;
      r_mode    <= 1'b0;
      r_p_vld   <= 1'b0;
      r_smp_cnt <= 6'd0;
      r_blk_cnt <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_p_vld <= w_pix_acc;
      if (w_pix_acc) begin
        if (r_pix_cnt == 8'd0) r_mode <= i_mode_420;
        r_pix_cnt <= w_pix_last ? 8'd0 : r_pix_cnt + 8'd1;
      end
      if (w_blk_xfer) begin
        r_smp_cnt <= r_smp_cnt + 6'd1;
        if (w_mcu_end)      r_blk_cnt <= 3'd0;
        else if (w_blk_end) r_blk_cnt <= r_blk_cnt + 3'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_pix_ready = 1'b0;
    o_blk_valid = 1'b0;
    case (r_state)
      S_FILL: begin
        o_pix_ready = w_fill;
        if (w_pix_acc && w_pix_last) w_state_nxt = S_CONV;
      end
      // lets the last pixel's conversion land in the buffer before draining
      S_CONV: w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        o_blk_valid = 1'b1;
        if (w_blk_xfer && w_mcu_end) w_state_nxt = S_FILL;
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_pix_acc) begin
      r_p_r   <= i_pix_r;
      r_p_g   <= i_pix_g;
      r_p_b   <= i_pix_b;
      r_p_row <= w_row;
      r_p_col <= w_col;
      r_p_420 <= w_mode;
    end
  end

  function automatic logic [7:0] sat8(input logic signed [20:0] v);
    if (v > 21'sd127)       sat8 = 8'h7f;
    else if (v < -21'sd128) sat8 = 8'h80;
    else                    sat8 = v[7:0];
  endfunction

  logic signed [20:0] w_r, w_g, w_b, w_y_sum, w_cb_sum, w_cr_sum;
  logic [7:0]         w_y8, w_cb8, w_cr8;
  logic signed [10:0] w_cb_ext, w_cr_ext, w_cb_q, w_cr_q;
  logic [7:0]         w_cb_avg, w_cr_avg;
  logic [5:0]         w_y_idx, w_q_idx;
  logic [1:0]         w_y_blk;
  logic [2:0]         w_acc_i;

  assign w_r      = $signed({13'd0, r_p_r});
  assign w_g      = $signed({13'd0, r_p_g});
  assign w_b      = $signed({13'd0, r_p_b});
  assign w_y_sum  = 21'sd306 * w_r + 21'sd601 * w_g + 21'sd117 * w_b + 21'sd512;
  assign w_cb_sum = 21'sd512 * w_b - 21'sd173 * w_r - 21'sd339 * w_g + 21'sd512;
  assign w_cr_sum = 21'sd512 * w_r - 21'sd429 * w_g - 21'sd83 * w_b + 21'sd512;
  assign w_y8     = sat8((w_y_sum >>> FRAC) - 21'sd128);
  assign w_cb8    = sat8(w_cb_sum >>> FRAC);
  assign w_cr8    = sat8(w_cr_sum >>> FRAC);

  assign w_y_idx  = {r_p_row[2:0], r_p_col[2:0]};
  assign w_y_blk  = r_p_420 ? {r_p_row[3], r_p_col[3]} : 2'b00;
  assign w_q_idx  = {r_p_row[3:1], r_p_col[3:1]};
  assign w_acc_i  = r_p_col[3:1];
  assign w_cb_ext = $signed({{3{w_cb8[7]}}, w_cb8});
  assign w_cr_ext = $signed({{3{w_cr8[7]}}, w_cr8});
  // full quad sum on the odd-row, odd-column pixel; rounded mean always fits -128..127
  assign w_cb_q   = r_acc_cb[w_acc_i] + w_cb_ext + 11'sd2;
  assign w_cr_q   = r_acc_cr[w_acc_i] + w_cr_ext + 11'sd2;
  assign w_cb_avg = sat8(21'(w_cb_q >>> 2));
  assign w_cr_avg = sat8(21'(w_cr_q >>> 2));

  always_ff @(posedge i_clk) begin
    if (r_p_vld) begin
      r_ybuf[{w_y_blk, w_y_idx}] <= w_y8;
      if (!r_p_420) begin
        r_cbbuf[w_y_idx] <= w_cb8;
        r_crbuf[w_y_idx] <= w_cr8;
      end else if (!r_p_row[0]) begin
        // even row: even column starts the pair sum, odd column adds to it
        r_acc_cb[w_acc_i] <= r_p_col[0] ? r_acc_cb[w_acc_i] + w_cb_ext : w_cb_ext;
        r_acc_cr[w_acc_i] <= r_p_col[0] ? r_acc_cr[w_acc_i] + w_cr_ext : w_cr_ext;
      end else if (!r_p_col[0]) begin
        r_acc_cb[w_acc_i] <= r_acc_cb[w_acc_i] + w_cb_ext;
        r_acc_cr[w_acc_i] <= r_acc_cr[w_acc_i] + w_cr_ext;
      end else begin
        r_cbbuf[w_q_idx] <= w_cb_avg;
        r_crbuf[w_q_idx] <= w_cr_avg;
      end
    end
  end

  always_comb begin
    w_rd = 8'd0;
    case (w_blk_id)
      3'd4:    w_rd = r_cbbuf[r_smp_cnt];
      3'd5:    w_rd = r_crbuf[r_smp_cnt];
      default: w_rd = r_ybuf[{w_blk_id[1:0], r_smp_cnt}];
    endcase
  end

  assign o_blk_data  = w_drain ? {{8{w_rd[7]}}, w_rd} : 16'd0;
  assign o_blk_id    = w_blk_id;
  assign o_blk_first = w_drain && (r_smp_cnt == 6'd0);
  assign o_blk_last  = w_drain && w_mcu_end;

endmodule

// File: tb/tb_mcu_block_builder.sv
// Purpose : directed bench for mcu_block_builder with a scoreboard of expected block samples.
// Latency : checks the last-pixel -> first-sample timing explicitly.
// Backpr. : drives i_blk_ready constant-high or random; every valid cycle is compared to the queue head.
module tb_mcu_block_builder;

  logic        i_clk = 1'b0;
  logic        i_rst, i_mode_420, i_pix_valid, i_blk_ready;
  logic [7:0]  i_pix_r, i_pix_g, i_pix_b;
  logic        o_pix_ready, o_blk_valid, o_blk_first, o_blk_last;
  logic [15:0] o_blk_data;
  logic [2:0]  o_blk_id;

  always #5 i_clk = ~i_clk;

  mcu_block_builder #(.FRAC(10)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_mode_420(i_mode_420),
    .i_pix_r(i_pix_r), .i_pix_g(i_pix_g), .i_pix_b(i_pix_b),
    .i_pix_valid(i_pix_valid), .o_pix_ready(o_pix_ready),
    .o_blk_data(o_blk_data), .o_blk_valid(o_blk_valid), .i_blk_ready(i_blk_ready),
    .o_blk_id(o_blk_id), .o_blk_first(o_blk_first), .o_blk_last(o_blk_last)
  );

  typedef struct packed {
    logic [15:0] d;
    logic [2:0]  id;
    logic        f;
    logic        l;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int pr[256], pg[256], pb[256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int sat(input int v);
    return (v > 127) ? 127 : ((v < -128) ? -128 : v);
  endfunction
  function automatic int cy(input int p);
    return sat(((306*pr[p] + 601*pg[p] + 117*pb[p] + 512) >>> 10) - 128);
  endfunction
  function automatic int ccb(input int p);
    return sat((-173*pr[p] - 339*pg[p] + 512*pb[p] + 512) >>> 10);
  endfunction
  function automatic int ccr(input int p);
    return sat((512*pr[p] - 429*pg[p] - 83*pb[p] + 512) >>> 10);
  endfunction

  task automatic push(input int v, input int id, input int i);
    exp_t e;
    logic [31:0] vv;
    vv   = v;
    e.d  = vv[15:0];
    e.id = 3'(id);
    e.f  = (i == 0);
    e.l  = (i == 63) && (id == 5);
    q.push_back(e);
  endtask

  task automatic build(input logic m);
    int v, s, qr, qc;
    if (!m) begin
      for (int i = 0; i < 64; i++) push(cy(i), 0, i);
      for (int i = 0; i < 64; i++) push(ccb(i), 4, i);
      for (int i = 0; i < 64; i++) push(ccr(i), 5, i);
    end else begin
      for (int k = 0; k < 4; k++)
        for (int i = 0; i < 64; i++) begin
          v = cy(((k >> 1)*8 + i/8)*16 + (k & 1)*8 + i%8);
          push(v, k, i);
        end
      for (int k = 4; k < 6; k++)
        for (int i = 0; i < 64; i++) begin
          qr = 2*(i/8); qc = 2*(i%8); s = 0;
          for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++)
              s += (k == 4) ? ccb((qr+dr)*16 + qc+dc) : ccr((qr+dr)*16 + qc+dc);
          push((s + 2) >>> 2, k, i);
        end
    end
  endtask

  task automatic fill_const(input int r, input int g, input int b);
    for (int i = 0; i < 256; i++) begin pr[i] = r; pg[i] = g; pb[i] = b; end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 256; i++) begin
      pr[i] = $urandom_range(0, 255); pg[i] = $urandom_range(0, 255); pb[i] = $urandom_range(0, 255);
    end
  endtask

  // Feeds one MCU (mode flipped after the first pixel, which must be ignored),
  // then checks the t+1 / t+2 handover timing.
  task automatic send(input logic m);
    int n, w;
    n = m ? 256 : 64;
    i_mode_420 = m;
    for (int i = 0; i < n; i++) begin
      i_pix_valid = 1'b1;
      i_pix_r = 8'(pr[i]); i_pix_g = 8'(pg[i]); i_pix_b = 8'(pb[i]);
      if (i == 1) i_mode_420 = ~m;
      w = 0;
      while (!o_pix_ready && w < 100) begin @(posedge i_clk); #1; w++; end
      if (w >= 100) chk("pix_ready_timeout", 32'd0, 32'd1);
      @(posedge i_clk); #1;
    end
    chk("t1_pix_ready", 32'(o_pix_ready), 32'd0);
    chk("t1_blk_valid", 32'(o_blk_valid), 32'd0);
    i_pix_r = 8'($urandom_range(0, 255));
    @(posedge i_clk); #1;
    chk("t2_blk_valid", 32'(o_blk_valid), 32'd1);
  endtask

  // Compares every valid cycle against the queue head (so a stall must hold the
  // same values); pops on transfer. Pixels offered throughout must be ignored.
  task automatic drain(input bit rnd, input int stop_after);
    int got, cyc;
    exp_t e;
    got = 0; cyc = 0;
    while (q.size() > 0 && got != stop_after && cyc < 5000) begin
      i_blk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      i_pix_valid = (q.size() > 1);
      i_pix_r     = 8'($urandom_range(0, 255));
      @(negedge i_clk);
      if (o_blk_valid) begin
        e = q[0];
        chk("blk_data",  32'(o_blk_data),  32'(e.d));
        chk("blk_id",    32'(o_blk_id),    32'(e.id));
        chk("blk_first", 32'(o_blk_first), 32'(e.f));
        chk("blk_last",  32'(o_blk_last),  32'(e.l));
        chk("drain_pix_ready", 32'(o_pix_ready), 32'd0);
        if (i_blk_ready) begin
          void'(q.pop_front());
          got++;
        end
      end
      @(posedge i_clk); #1;
      cyc++;
    end
    i_pix_valid = 1'b0;
    if (cyc >= 5000) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic post_mcu();
    chk("post_blk_valid", 32'(o_blk_valid), 32'd0);
    chk("post_pix_ready", 32'(o_pix_ready), 32'd1);
  endtask

  task automatic run_mcu(input logic m, input bit rnd);
    build(m);
    send(m);
    drain(rnd, -1);
    post_mcu();
  endtask

  initial begin
    i_rst = 1'b1; i_mode_420 = 1'b0; i_pix_valid = 1'b0; i_blk_ready = 1'b1;
    i_pix_r = 8'd0; i_pix_g = 8'd0; i_pix_b = 8'd0;
    @(posedge i_clk); #1;
    chk("rst_pix_ready",  32'(o_pix_ready), 32'd0);
    chk("rst_blk_valid",  32'(o_blk_valid), 32'd0);
    chk("rst_blk_data",   32'(o_blk_data),  32'd0);
    chk("rst_blk_id",     32'(o_blk_id),    32'd0);
    chk("rst_blk_first",  32'(o_blk_first), 32'd0);
    chk("rst_blk_last",   32'(o_blk_last),  32'd0);
    i_rst = 1'b0; #1;
    chk("rst_release_pix_ready", 32'(o_pix_ready), 32'd1);

    // 4:4:4 white: Y 127, Cb/Cr 0
    fill_const(255, 255, 255); run_mcu(1'b0, 1'b0);
    // 4:4:4 red: Y -52, Cb -43, Cr saturates at 127
    fill_const(255, 0, 0);     run_mcu(1'b0, 1'b0);
    // 4:2:0 black: Y -128, chroma 0
    fill_const(0, 0, 0);       run_mcu(1'b1, 1'b0);
    // 4:2:0 left-white / right-black with a red pixel at (0,0): Cr[0] = 32
    for (int i = 0; i < 256; i++) begin
      pr[i] = (i % 16 < 8) ? 255 : 0; pg[i] = pr[i]; pb[i] = pr[i];
    end
    pr[0] = 255; pg[0] = 0; pb[0] = 0;
    run_mcu(1'b1, 1'b0);
    // back-to-back random MCUs under random backpressure
    fill_rand(); run_mcu(1'b1, 1'b1);
    fill_rand(); run_mcu(1'b0, 1'b1);
    fill_rand(); run_mcu(1'b1, 1'b1);

    // reset after 100 drain samples aborts the MCU
    fill_const(255, 255, 255);
    build(1'b0); send(1'b0); drain(1'b0, 100);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    chk("abort_blk_valid", 32'(o_blk_valid), 32'd0);
    chk("abort_pix_ready_in_rst", 32'(o_pix_ready), 32'd0);
    i_rst = 1'b0; #1;
    chk("abort_pix_ready", 32'(o_pix_ready), 32'd1);
    q.delete();
    fill_const(255, 0, 0); run_mcu(1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
